// File: rtl/serial_pkg.sv
// Shared definitions for the serial_tx transmitter: FSM encoding and line levels.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap
// cycle with a one-cycle tick. A synchronous clear realigns it to a frame start.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Divider counter: cleared at frame start, wraps at the end of each bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first,
// optional even parity, STOP_BITS stop bits. tx is a registered output.
// Optional feature: define SERIAL_TX_PARITY_EN to insert the parity bit.
//
// state  | meaning
// IDLE   | line high, in_ready=1, waiting for a handshake
// START  | driving the start bit (0) for one bit period
// DATA   | driving shreg[0], shifting right at each bit boundary
// PARITY | driving the even-parity bit (parity builds only)
// STOP   | driving stop bit(s) (1); done pulses in the final cycle
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_e            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [BCW-1:0]    bit_cnt;
  logic              stop_cnt;
  logic              tick;
  logic              accept;
  logic              last_bit;
  logic              last_stop;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity;
`endif

  assign accept     = in_valid && in_ready;
  assign shreg_next = shreg >> 1;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign last_stop  = (stop_cnt == LAST_STOP);

  // The divider restarts on the accepting edge so the start bit gets a full period
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .en   (busy),
    .tick (tick)
  );

  // Frame sequencer; tx is loaded with the level of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= TX_IDLE_LEVEL;
      busy     <= 1'b0;
      in_ready <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            tx       <= START_LEVEL;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            shreg    <= in_data;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity   <= ^in_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg_next;
            if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= TX_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg_next[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= TX_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              state    <= IDLE;
              tx       <= TX_IDLE_LEVEL;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= TX_IDLE_LEVEL;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // done marks the last cycle of the final stop bit
  assign done = (state == STOP) && tick && last_stop;

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter, i.e. the sending end of the team's single-wire serial link.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts out a frame on tx: start bit (0), data LSB first, optional parity, then stop bit(s) (1).
- Bit timing comes from an internal divider.
- Built from flip-flop registers with asynchronous reset; sits between a producer block and an output pad.

Parameters:
DATA_W  8  data bits per frame (1..16)
CLKS_PER_BIT  4  clk cycles per serial bit (>=2)
STOP_BITS  1  number of stop bits (1 or 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset; all state clears immediately on assertion
in_data  input  DATA_W  word to transmit; sampled on handshake
in_valid  input  1  producer has a word
in_ready  output  1  transmitter can accept a word
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values: tx=1, busy=0, in_ready=1, done=0, state=IDLE, counters=0, shift register=0.
- Handshake: the word is accepted on a rising edge where in_valid && in_ready. in_ready=1 only in IDLE (registered, no combinational path from in_valid). in_data is latched into the shift register at acceptance.
- States:
  - IDLE: tx=1. On handshake go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shreg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; bit counter 0..DATA_W-1. After the last bit go to PARITY if enabled, else STOP.
  - PARITY: one bit period (see Optional Feature), then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. done pulses in the final cycle; next state IDLE.
- Latency: tx falls on the first cycle after the handshake edge; it is a registered output.
- Frame length: (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- busy=1 from the cycle after acceptance through the last stop cycle. in_ready returns to 1 the cycle after done.
- Divider counts 0..CLKS_PER_BIT-1 and wraps; bit advance occurs at the wrap. Width is $clog2(CLKS_PER_BIT); bit counter width is $clog2(DATA_W+1).
- in_valid held high across frames: the next word is accepted in the first IDLE cycle, giving exactly one idle-high cycle between frames.
- in_valid toggling while busy is ignored and never corrupts the shift register.
- rst asserted mid-frame: tx returns to 1 immediately (asynchronously); the partial frame is abandoned with no done pulse; in_ready=1 after release.
- in_valid asserted during reset is not accepted.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA, and tx = XOR of all data bits (even parity) for one bit period. Parity is computed at acceptance and held in a register.
- Undefined: the PARITY state and register do not exist; DATA goes directly to STOP.

Decomposition:
- Shared package serial_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP (3-bit encoding)
  - constants: TX_IDLE_LEVEL=1'b1, START_LEVEL=1'b0
- One natural sub-module: baud_tick, a divider producing a one-cycle tick every CLKS_PER_BIT cycles. It restarts on a sync clear asserted at frame start.

Test Plan:
- Reset: assert rst mid-simulation with no clock edge -> tx=1, busy=0, in_ready=1, done=0 immediately.
- Single frame: in_data=8'hA5, one valid cycle (default params) -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses at cycle 40 after handshake; in_ready=1 at cycle 41.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF -> two frames separated by exactly one tx=1 idle cycle; both words sent, no overlap.
- Mid-frame reset: pulse rst during data bit 3 of 8'h3C -> tx=1 asynchronously, no done pulse; the next frame with 8'h81 is transmitted intact.
- Ignore while busy: toggle in_valid with 8'h55 during a frame of 8'hF0 -> only 8'hF0 is transmitted; 8'h55 is accepted only once IDLE is reached.
- SERIAL_TX_PARITY_EN defined, 8'h07 -> parity bit 1 appears after data bit 7; frame is 44 cycles. With 8'h03 -> parity bit 0.
